// File: rtl/onehot_encoder_reg.sv
// onehot_encoder_reg
//   Registered N-to-log2(N) encoder with a valid/ready handshake on both sides.
//   Returns the index of the lowest set bit of each accepted word. Any word that
//   is zero or has more than one bit set is flagged with err and also bumps a
//   saturating error counter.
//
//   Storage is one output register plus a one-entry skid register. Because of
//   the skid entry, x_ready depends only on enable and registered state and
//   never on y_ready.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     0 blocks new input words; buffered words still drain
//   x          request vector (N bits)
//   x_valid    x carries a word
//   x_ready    block can accept a word this cycle
//   y          binary index of the lowest set bit (W bits)
//   err        word was not exactly one-hot (qualified by y_valid)
//   y_valid    y/err hold a word
//   y_ready    downstream consumes the word
//   err_count  saturating count of accepted non-one-hot words
module onehot_encoder_reg #(
    parameter int N         = 4,
    parameter int ERR_CNT_W = 8,
    localparam int W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N-1:0]         x,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic [W-1:0]         y,
    output logic                 err,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef struct packed {
        logic [W-1:0] y;
        logic         err;
    } word_t;

    word_t enc;
    word_t skid;
    logic  s_valid;
    logic  onehot;
    logic  accept;
    logic  pop;

    // Scan from the top down so that the last hit is the lowest set bit.
    always_comb begin
        enc.y = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) enc.y = W'(i);
        end
        // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
        onehot  = (x != '0) && ((x & (x - N'(1))) == '0);
        enc.err = ~onehot;
    end

    assign x_ready = enable & ~s_valid;
    assign accept  = x_valid & x_ready;
    assign pop     = y_valid & y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            err     <= 1'b0;
            y_valid <= 1'b0;
            skid    <= '0;
            s_valid <= 1'b0;
        end else if (s_valid) begin
            // The skid is full, so x_ready is low and no accept can occur here.
            if (pop) begin
                y       <= skid.y;
                err     <= skid.err;
                s_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!y_valid || pop) begin
                y       <= enc.y;
                err     <= enc.err;
                y_valid <= 1'b1;
            end else begin
                skid    <= enc;
                s_valid <= 1'b1;
            end
        end else if (pop) begin
            y_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && !onehot && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_reg.sv
module tb_onehot_encoder_reg;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] x;
    logic         x_valid;
    logic         x_ready, x_ready2;
    logic [W-1:0] y, y2;
    logic         err, err2;
    logic         y_valid, y_valid2;
    logic         y_ready;
    logic [7:0]   err_count;
    logic [1:0]   err_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onehot_encoder_reg #(.N(N), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .x(x), .x_valid(x_valid),
        .x_ready(x_ready), .y(y), .err(err), .y_valid(y_valid),
        .y_ready(y_ready), .err_count(err_count)
    );

    // Narrow counter instance for saturation; shares all inputs with dut.
    onehot_encoder_reg #(.N(N), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .x(x), .x_valid(x_valid),
        .x_ready(x_ready2), .y(y2), .err(err2), .y_valid(y_valid2),
        .y_ready(y_ready), .err_count(err_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: bottom-up search for the first set bit.
    function automatic logic [W:0] model_enc(input logic [N-1:0] v);
        int ones = 0;
        int idx  = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                ones++;
                if (idx < 0) idx = i;
            end
        end
        if (idx < 0) idx = 0;
        return {W'(idx), (ones != 1)};
    endfunction

    // Scoreboard: expected {y,err} queued at accept, compared at pop.
    logic [W:0] sb[$];
    int cnt8 = 0;
    int cnt2 = 0;

    always @(negedge clk or negedge rst_n) begin
        logic [W:0] e;
        if (!rst_n) begin
            sb.delete();
            cnt8 = 0;
            cnt2 = 0;
        end else if (!clk) begin
            chk("sb_y_valid", y_valid, sb.size() > 0);
            chk("sb_x_ready", x_ready, enable && (sb.size() < 2));
            chk("sb_err_count", err_count, cnt8);
            chk("sb_err_count_sat", err_count2, cnt2);
            if (y_valid && y_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pop", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_y", y, e[W:1]);
                    chk("sb_err", err, e[0]);
                end
            end
            if (x_valid && x_ready) begin
                e = model_enc(x);
                sb.push_back(e);
                if (e[0]) begin
                    if (cnt8 < 255) cnt8++;
                    if (cnt2 < 3) cnt2++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] x;
        int           y;
        logic         err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b0001, 0, 1'b0};
        vecs[1] = '{4'b0010, 1, 1'b0};
        vecs[2] = '{4'b0100, 2, 1'b0};
        vecs[3] = '{4'b1000, 3, 1'b0};
        vecs[4] = '{4'b0000, 0, 1'b1};
        vecs[5] = '{4'b1010, 1, 1'b1};
        vecs[6] = '{4'b0100, 2, 1'b0};
        vecs[7] = '{4'b1111, 0, 1'b1};
        vecs[8] = '{4'b1100, 2, 1'b1};

        rst_n = 1'b0; enable = 1'b1; x = '0; x_valid = 1'b0; y_ready = 1'b1;
        #3;
        chk("rst_y", y, 0);
        chk("rst_err", err, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_x_ready", x_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Streaming and error words, one accept per cycle, y_ready held high.
        for (int i = 0; i < 9; i++) begin
            x = vecs[i].x;
            x_valid = 1'b1;
            step();
            chk("tbl_y_valid", y_valid, 1);
            chk("tbl_y", y, vecs[i].y);
            chk("tbl_err", err, vecs[i].err);
            if (i == 3) chk("tbl_cnt_after_onehot", err_count, 0);
            if (i == 4) chk("tbl_cnt_zero_word", err_count, 1);
            if (i == 6) chk("tbl_cnt_held", err_count, 2);
        end
        x_valid = 1'b0;
        step();
        chk("tbl_drained", y_valid, 0);
        chk("tbl_cnt8", err_count, 4);
        chk("tbl_cnt2_sat", err_count2, 3);

        // Backpressure: second word lands in the skid entry.
        y_ready = 1'b0;
        x = 4'b0010; x_valid = 1'b1;
        step();
        x = 4'b0100;
        step();
        chk("bp_x_ready_full", x_ready, 0);
        chk("bp_y_head", y, 1);
        x = 4'b1000;
        step();
        chk("bp_y_stable", y, 1);
        chk("bp_x_ready_still", x_ready, 0);
        x_valid = 1'b0;
        y_ready = 1'b1;
        step();
        chk("bp_y_second", y, 2);
        chk("bp_x_ready_back", x_ready, 1);
        step();
        chk("bp_drained", y_valid, 0);

        // Enable gating with a word pending in the output register.
        y_ready = 1'b0;
        x = 4'b1000; x_valid = 1'b1;
        step();
        enable = 1'b0;
        x = 4'b0001;
        #1;
        chk("en_x_ready_low", x_ready, 0);
        chk("en_pending_y", y, 3);
        y_ready = 1'b1;
        step();
        chk("en_drained", y_valid, 0);
        step();
        chk("en_no_accept", y_valid, 0);
        chk("en_cnt_held", err_count, 4);
        enable = 1'b1;
        step();
        chk("en_accept_y_valid", y_valid, 1);
        chk("en_accept_y", y, 0);
        x_valid = 1'b0;
        step();

        // Asynchronous reset between edges with both registers full.
        y_ready = 1'b0;
        x = 4'b0001; x_valid = 1'b1;
        step();
        x = 4'b0010;
        step();
        x_valid = 1'b0;
        chk("ar_full", x_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_y", y, 0);
        chk("ar_err", err, 0);
        chk("ar_y_valid", y_valid, 0);
        chk("ar_err_count", err_count, 0);
        chk("ar_x_ready", x_ready, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        y_ready = 1'b1;
        step();
        chk("ar_idle", y_valid, 0);
        x = 4'b0100; x_valid = 1'b1;
        step();
        chk("ar_first_y", y, 2);
        chk("ar_first_valid", y_valid, 1);
        x_valid = 1'b0;
        step();
        chk("ar_only_one", y_valid, 0);

        // Saturation on the 2-bit counter.
        x = 4'b0000; x_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_cnt2", err_count2, (i < 3) ? i + 1 : 3);
            chk("sat_cnt8", err_count, i + 1);
        end
        x_valid = 1'b0;
        step();
        step();
        chk("end_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_reg.md
Name: onehot_encoder_reg

Overview:
- Registered N-to-log2(N) encoder; the inverse of the team's 2-to-4 enable decoder.
- Accepts a request/one-hot vector over a valid/ready handshake and returns the binary index of the lowest set bit.
- Flags every word that is not exactly one-hot and keeps a saturating count of those words.
- Sits between request sources (interrupt lines, grant vectors) and logic that consumes a binary select.

Parameters:
- N, 4: width of input vector x; legal range N >= 2.
- ERR_CNT_W, 8: width of err_count.
- Derived localparam W = $clog2(N): width of y.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when 0, no new input words are accepted.
- x  input  N  request vector.
- x_valid  input  1  x carries a word.
- x_ready  output  1  block can accept a word this cycle.
- y  output  W  binary index of the lowest set bit of the accepted word.
- err  output  1  accepted word was zero or had more than one bit set; qualified by y_valid.
- y_valid  output  1  y/err hold a word.
- y_ready  input  1  downstream consumes the word.
- err_count  output  ERR_CNT_W  count of accepted non-one-hot words; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, err=0, y_valid=0, err_count=0.
  - Skid entry is cleared (s_valid=0).
  - This takes effect immediately, including mid-transfer. Any buffered words are discarded.
- Encoding: y = index of the lowest set bit of x.
  - x==0: y=0, err=1.
  - More than one bit set: y = lowest index, err=1.
  - Exactly one bit set: err=0.
- Storage: one output register (y, err, y_valid) plus a one-entry skid register (s_y, s_err, s_valid).
- x_ready = enable & ~s_valid. This is combinational from enable and registered s_valid only; it never depends on y_ready.
- Definitions: accept = x_valid & x_ready; pop = y_valid & y_ready.
- Next-state rules, evaluated on each clock edge:
  - s_valid=1, pop: output register <= skid; s_valid <= 0.
  - s_valid=1, no pop: hold everything. Input is not accepted because x_ready=0.
  - s_valid=0, accept, and (!y_valid or pop): output register <= encoded x; y_valid <= 1.
  - s_valid=0, accept, y_valid and no pop: skid <= encoded x; s_valid <= 1. The output register holds.
  - s_valid=0, no accept, pop: y_valid <= 0.
  - Otherwise: hold.
- Latency: 1 cycle from accept edge to y_valid when the output register is free.
- Throughput: 1 word/cycle while y_ready=1.
- Ordering: words leave in acceptance order. No word is dropped or duplicated.
- y and err stay stable while y_valid=1 and y_ready=0.
- err_count:
  - Increments by 1 on the edge of each accept whose word is not one-hot.
  - Saturates at 2^ERR_CNT_W-1.
  - Only reset clears it.
- enable=0:
  - x_ready=0.
  - Words already in the output/skid registers still drain normally.
  - err_count does not change.
- x_valid asserted while x_ready=0: no state change. The source must hold x.

Test Plan:
1. Reset check: assert rst_n=0 asynchronously, between edges, while y_valid=1 and s_valid=1 -> y=0, err=0, y_valid=0, err_count=0 and x_ready=enable immediately; after release, first output is the next accepted word only.
2. Streaming, N=4, enable=1, y_ready=1: x=0001,0010,0100,1000 on consecutive cycles -> y=0,1,2,3 each one cycle after its accept, err=0, y_valid high for 4 consecutive cycles, err_count=0.
3. Error words: accept x=0000 -> y=0, err=1, err_count=1; then accept x=1010 -> y=1, err=1, err_count=2; then x=0100 -> y=2, err=0, err_count stays 2.
4. Backpressure, y_ready=0: accept 0010 then 0100 -> y=1 held; second word sits in skid; x_ready=0 the cycle after the second accept. Raise y_ready -> y=1 then y=2 on successive cycles; x_ready returns to 1 after the skid drains; no loss or reorder.
5. Enable gating: enable=0 with x_valid=1, x=0001 -> x_ready=0, no accept, err_count unchanged. A previously pending word y=3 still drains when y_ready=1. enable=1 -> word accepted, y=0.
6. Saturation, ERR_CNT_W=2: accept five x=0000 words -> err_count=1,2,3,3,3.
